// File: rtl/mem_arbiter_axil.sv
// N-channel memory request arbiter driving a single AXI4-Lite master port.
// One transaction in flight; misaligned or malformed requests complete with err and never reach the bus.
module mem_arbiter_axil #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 1,
   parameter int CHK_ALIGN = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
   input  logic [NUM_CH*DATA_W-1:0]      ch_wdata,
   input  logic [NUM_CH*(DATA_W/8)-1:0]  ch_mask,
   input  logic [NUM_CH*2-1:0]           ch_size,
   input  logic [NUM_CH-1:0]             ch_r_en,
   input  logic [NUM_CH-1:0]             ch_w_en,
   output logic [NUM_CH*DATA_W-1:0]      ch_rdata,
   output logic [NUM_CH-1:0]             ch_finish,
   output logic [NUM_CH-1:0]             ch_err,
   output logic [ADDR_W-1:0]             axi_araddr,
   output logic                          axi_arvalid,
   input  logic                          axi_arready,
   input  logic [DATA_W-1:0]             axi_rdata,
   input  logic [1:0]                    axi_rresp,
   input  logic                          axi_rvalid,
   output logic                          axi_rready,
   output logic [ADDR_W-1:0]             axi_awaddr,
   output logic                          axi_awvalid,
   input  logic                          axi_awready,
   output logic [DATA_W-1:0]             axi_wdata,
   output logic [DATA_W/8-1:0]           axi_wstrb,
   output logic                          axi_wvalid,
   input  logic                          axi_wready,
   input  logic [1:0]                    axi_bresp,
   input  logic                          axi_bvalid,
   output logic                          axi_bready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CHK, S_RADDR, S_RDATA, S_WADDR, S_WRESP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     grant_q, grant_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   mask_q, mask_d;
   logic [1:0]          size_q, size_d;
   logic                rd_q, rd_d, wr_q, wr_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic [NUM_CH-1:0]   req;
   logic                arb_found;
   logic [CH_W-1:0]     arb_idx;
   logic                bad_req;

   assign req        = ch_r_en | ch_w_en;
   assign axi_araddr = addr_q;
   assign axi_awaddr = addr_q;
   assign axi_wdata  = wdata_q;
   assign axi_wstrb  = mask_q;

   // Loops run from lowest to highest priority so the last hit is the winner.
   always_comb begin
      int j;
      arb_found = 1'b0;
      arb_idx   = '0;
      j         = 0;
      if (ARB_MODE == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[CH_W'(i)]) begin
               arb_found = 1'b1;
               arb_idx   = CH_W'(i);
            end
         end
      end else begin
         for (int k = NUM_CH; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % NUM_CH;
            if (req[CH_W'(j)]) begin
               arb_found = 1'b1;
               arb_idx   = CH_W'(j);
            end
         end
      end
   end

   assign bad_req = (rd_q && wr_q) || (size_q == 2'd3) ||
                    ((CHK_ALIGN != 0) && (((size_q == 2'd1) && addr_q[0]) ||
                                          ((size_q == 2'd2) && (addr_q[1:0] != 2'b00))));

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      size_d      = size_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_bready  = 1'b0;
      ch_finish   = '0;
      ch_err      = '0;
      ch_rdata    = '0;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d   = arb_idx;
               ptr_d     = arb_idx;
               addr_d    = ch_addr[arb_idx*ADDR_W +: ADDR_W];
               wdata_d   = ch_wdata[arb_idx*DATA_W +: DATA_W];
               mask_d    = ch_mask[arb_idx*STRB_W +: STRB_W];
               size_d    = ch_size[arb_idx*2 +: 2];
               rd_d      = ch_r_en[arb_idx];
               wr_d      = ch_w_en[arb_idx];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b0;
               state_d   = S_CHK;
            end
         end
         S_CHK: begin
            if (bad_req) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (rd_q) begin
               state_d = S_RADDR;
            end else begin
               state_d = S_WADDR;
            end
         end
         S_RADDR: begin
            axi_arvalid = 1'b1;
            if (axi_arready) state_d = S_RDATA;
         end
         S_RDATA: begin
            axi_rready = 1'b1;
            if (axi_rvalid) begin
               rdata_d = axi_rdata;
               err_d   = (axi_rresp != 2'b00);
               state_d = S_DONE;
            end
         end
         S_WADDR: begin
            // AW and W retire independently; whichever lands second moves us on.
            axi_awvalid = !aw_done_q;
            axi_wvalid  = !w_done_q;
            aw_done_d   = aw_done_q | (axi_awvalid & axi_awready);
            w_done_d    = w_done_q | (axi_wvalid & axi_wready);
            if (aw_done_d && w_done_d) state_d = S_WRESP;
         end
         S_WRESP: begin
            axi_bready = 1'b1;
            if (axi_bvalid) begin
               err_d   = (axi_bresp != 2'b00);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            ch_finish[grant_q]                = 1'b1;
            ch_err[grant_q]                   = err_q;
            ch_rdata[grant_q*DATA_W +: DATA_W] = rdata_q;
            state_d                           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= CH_W'(NUM_CH - 1);
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         size_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         size_q    <= size_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_axil.sv
// Scoreboard bench: a round-robin instance with a configurable-latency slave, plus a fixed-priority instance.
`timescale 1ns/1ps
module tb_mem_arbiter_axil;
   localparam int NCH = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam logic [31:0] XK = 32'h5A5A_5A5A;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic [NCH*SW-1:0] ch_mask;
   logic [NCH*2-1:0]  ch_size;
   logic [NCH-1:0]    ch_r_en, ch_w_en;
   logic [NCH*DW-1:0] ch_rdata;
   logic [NCH-1:0]    ch_finish, ch_err;
   logic [AW-1:0]     axi_araddr, axi_awaddr;
   logic [DW-1:0]     axi_rdata, axi_wdata;
   logic [SW-1:0]     axi_wstrb;
   logic [1:0]        axi_rresp, axi_bresp;
   logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

   logic [NCH*AW-1:0] fx_addr;
   logic [NCH*DW-1:0] fx_wdata;
   logic [NCH*SW-1:0] fx_mask;
   logic [NCH*2-1:0]  fx_size;
   logic [NCH-1:0]    fx_r_en, fx_w_en;
   logic [NCH*DW-1:0] fx_rdata_o;
   logic [NCH-1:0]    fx_finish, fx_err;
   logic [AW-1:0]     fx_araddr, fx_awaddr;
   logic [DW-1:0]     fx_wdata_o;
   logic [SW-1:0]     fx_wstrb;
   logic fx_arvalid, fx_rready, fx_awvalid, fx_wvalid, fx_bready;

   mem_arbiter_axil #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .CHK_ALIGN(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_mask(ch_mask),
      .ch_size(ch_size), .ch_r_en(ch_r_en), .ch_w_en(ch_w_en), .ch_rdata(ch_rdata),
      .ch_finish(ch_finish), .ch_err(ch_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready));

   mem_arbiter_axil #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .CHK_ALIGN(1)) u_fx (
      .clk(clk), .rst_n(rst_n), .ch_addr(fx_addr), .ch_wdata(fx_wdata), .ch_mask(fx_mask),
      .ch_size(fx_size), .ch_r_en(fx_r_en), .ch_w_en(fx_w_en), .ch_rdata(fx_rdata_o),
      .ch_finish(fx_finish), .ch_err(fx_err),
      .axi_araddr(fx_araddr), .axi_arvalid(fx_arvalid), .axi_arready(1'b1),
      .axi_rdata(32'h0F0F_0F0F), .axi_rresp(2'b00), .axi_rvalid(1'b1), .axi_rready(fx_rready),
      .axi_awaddr(fx_awaddr), .axi_awvalid(fx_awvalid), .axi_awready(1'b1),
      .axi_wdata(fx_wdata_o), .axi_wstrb(fx_wstrb), .axi_wvalid(fx_wvalid), .axi_wready(1'b1),
      .axi_bresp(2'b00), .axi_bvalid(1'b1), .axi_bready(fx_bready));

   // Slave model for u_rr: each ready/valid comes up after a programmable number of waiting cycles.
   int ar_dly, r_dly, aw_dly, w_dly, b_dly;
   logic fix_en;
   logic [31:0] fix_rdata;
   logic [1:0]  rresp_v, bresp_v;
   int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic r_pend, aw_seen, w_seen;
   logic [31:0] r_data, last_awaddr, last_wdata;
   logic [3:0]  last_wstrb;
   int ar_hs, aw_hs, w_hs, arv_cyc, awv_cyc, cyc;

   always_comb begin
      axi_arready = axi_arvalid && (ar_cnt >= ar_dly);
      axi_rvalid  = r_pend && (r_cnt >= r_dly);
      axi_rdata   = axi_rvalid ? r_data : '0;
      axi_rresp   = axi_rvalid ? rresp_v : 2'b00;
      axi_awready = axi_awvalid && !aw_seen && (aw_cnt >= aw_dly);
      axi_wready  = axi_wvalid && !w_seen && (w_cnt >= w_dly);
      axi_bvalid  = aw_seen && w_seen && (b_cnt >= b_dly);
      axi_bresp   = axi_bvalid ? bresp_v : 2'b00;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
         r_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; r_data <= '0;
         ar_hs <= 0; aw_hs <= 0; w_hs <= 0; arv_cyc <= 0; awv_cyc <= 0;
         last_awaddr <= '0; last_wdata <= '0; last_wstrb <= '0;
      end else begin
         if (axi_arvalid) arv_cyc <= arv_cyc + 1;
         if (axi_awvalid) awv_cyc <= awv_cyc + 1;
         if (axi_arvalid && axi_arready) begin
            ar_cnt <= 0; r_pend <= 1'b1; ar_hs <= ar_hs + 1;
            r_data <= fix_en ? fix_rdata : (axi_araddr ^ XK);
         end else if (axi_arvalid) ar_cnt <= ar_cnt + 1;
         if (axi_rvalid && axi_rready) begin
            r_pend <= 1'b0; r_cnt <= 0;
         end else if (r_pend) r_cnt <= r_cnt + 1;
         if (axi_awvalid && axi_awready) begin
            aw_seen <= 1'b1; aw_cnt <= 0; aw_hs <= aw_hs + 1; last_awaddr <= axi_awaddr;
         end else if (axi_awvalid) aw_cnt <= aw_cnt + 1;
         if (axi_wvalid && axi_wready) begin
            w_seen <= 1'b1; w_cnt <= 0; w_hs <= w_hs + 1;
            last_wstrb <= axi_wstrb; last_wdata <= axi_wdata;
         end else if (axi_wvalid) w_cnt <= w_cnt + 1;
         if (axi_bvalid && axi_bready) begin
            aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0;
         end else if (aw_seen && w_seen) b_cnt <= b_cnt + 1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int ch; logic [31:0] rdata; logic err; int cy;} exp_t;
   exp_t sbq[$];
   int   fxq[$];
   int   checks = 0;
   int   errors = 0;
   logic ar_wait, aw_wait, w_wait;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int c, input logic [31:0] d, input logic e, input int cy);
      exp_t x;
      x.ch = c; x.rdata = d; x.err = e; x.cy = cy;
      sbq.push_back(x);
   endtask

   task automatic sb_monitor();
      exp_t x;
      ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
         end else begin
            if (ar_wait) chk("arvalid_hold", 64'(axi_arvalid), 64'd1);
            if (aw_wait) chk("awvalid_hold", 64'(axi_awvalid), 64'd1);
            if (w_wait)  chk("wvalid_hold",  64'(axi_wvalid),  64'd1);
            ar_wait = axi_arvalid && !axi_arready;
            aw_wait = axi_awvalid && !axi_awready;
            w_wait  = axi_wvalid && !axi_wready;
            for (int c = 0; c < NCH; c++) begin
               if (ch_finish[c]) begin
                  if (sbq.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_finish: channel %0d finished, none expected", c);
                  end else begin
                     x = sbq.pop_front();
                     chk("grant_ch", 64'(c), 64'(x.ch));
                     chk("rdata", 64'(ch_rdata[c*DW +: DW]), 64'(x.rdata));
                     chk("err", 64'(ch_err[c]), 64'(x.err));
                     if (x.cy >= 0) chk("finish_cycle", 64'(cyc), 64'(x.cy));
                  end
               end
               if (fx_finish[c]) begin
                  if (fxq.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_fx_finish: channel %0d finished, none expected", c);
                  end else begin
                     chk("fx_grant_ch", 64'(c), 64'(fxq.pop_front()));
                     chk("fx_rdata", 64'(fx_rdata_o[c*DW +: DW]), 64'h0F0F_0F0F);
                  end
               end
            end
         end
      end
   endtask

   task automatic set_req(input int c, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m, input logic [1:0] s);
      ch_addr[c*AW +: AW] = a;
      ch_wdata[c*DW +: DW] = d;
      ch_mask[c*SW +: SW] = m;
      ch_size[c*2 +: 2]   = s;
      ch_r_en[c] = rd;
      ch_w_en[c] = wr;
   endtask

   // Hold the request through n completions, then drop it after the last finish.
   task automatic hold_req(input int c, input int n, input bit fx);
      int got = 0;
      int t = 0;
      while (got < n && t < 300) begin
         @(negedge clk);
         t++;
         if (fx ? fx_finish[c] : ch_finish[c]) got++;
      end
      chk("req_completions", 64'(got), 64'(n));
      @(posedge clk); #1;
      if (fx) fx_r_en[c] = 1'b0;
      else begin
         ch_r_en[c] = 1'b0;
         ch_w_en[c] = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((sbq.size() != 0 || fxq.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("queue_drained", 64'(sbq.size() + fxq.size()), 64'd0);
      sbq.delete();
      fxq.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int n, s_ar, s_aw, s_w, s_arv, s_awv;
      int wr_dly[3][2];
      wr_dly = '{'{0, 1}, '{1, 0}, '{1, 1}};
      rst_n = 1'b0;
      ch_addr = '0; ch_wdata = '0; ch_mask = '0; ch_size = '0; ch_r_en = '0; ch_w_en = '0;
      fx_addr = '0; fx_wdata = '0; fx_mask = '0; fx_size = '0; fx_r_en = '0; fx_w_en = '0;
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
      fix_en = 1'b1; fix_rdata = '0; rresp_v = 2'b00; bresp_v = 2'b00; cyc = 0;
      fork sb_monitor(); join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
      chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
      chk("rst_wvalid",  64'(axi_wvalid),  64'd0);
      chk("rst_ready",   64'({axi_rready, axi_bready}), 64'd0);
      chk("rst_finish",  64'({ch_finish, ch_err}), 64'd0);
      chk("rst_rdata",   64'(ch_rdata[63:0]), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single read, slave one cycle late on both arready and rvalid.
      ar_dly = 1; r_dly = 1; fix_rdata = 32'hDEAD_BEEF;
      s_ar = ar_hs; s_arv = arv_cyc; n = cyc;
      push(0, 32'hDEAD_BEEF, 1'b0, n + 6);
      set_req(0, 1, 0, 32'h8000_0000, '0, 4'h0, 2'd2);
      hold_req(0, 1, 0);
      drain();
      chk("rd_ar_handshakes", 64'(ar_hs - s_ar), 64'd1);
      chk("rd_arvalid_cycles", 64'(arv_cyc - s_arv), 64'd2);
      ar_dly = 0; r_dly = 0;

      // Write with AW first, W first, and both together.
      for (int r = 0; r < 3; r++) begin
         aw_dly = wr_dly[r][0]; w_dly = wr_dly[r][1];
         s_aw = aw_hs; s_w = w_hs; n = cyc;
         push(1, '0, 1'b0, n + 5);
         set_req(1, 0, 1, 32'h8000_0010, 32'h1234_5678, 4'hF, 2'd2);
         hold_req(1, 1, 0);
         drain();
         chk("wr_aw_handshakes", 64'(aw_hs - s_aw), 64'd1);
         chk("wr_w_handshakes",  64'(w_hs - s_w),   64'd1);
         chk("wr_wstrb",  64'(last_wstrb),  64'hF);
         chk("wr_awaddr", 64'(last_awaddr), 64'h8000_0010);
         chk("wr_wdata",  64'(last_wdata),  64'h1234_5678);
      end
      aw_dly = 0; w_dly = 0;

      // Rejected requests: misaligned half/word, size 3, both enables.
      s_arv = arv_cyc; s_awv = awv_cyc;
      n = cyc; push(1, '0, 1'b1, n + 2);
      set_req(1, 1, 0, 32'h8000_0001, '0, 4'h0, 2'd1); hold_req(1, 1, 0); drain();
      n = cyc; push(1, '0, 1'b1, n + 2);
      set_req(1, 0, 1, 32'h8000_0002, 32'hAAAA_5555, 4'hF, 2'd2); hold_req(1, 1, 0); drain();
      n = cyc; push(2, '0, 1'b1, n + 2);
      set_req(2, 1, 0, 32'h8000_0020, '0, 4'h0, 2'd3); hold_req(2, 1, 0); drain();
      n = cyc; push(2, '0, 1'b1, n + 2);
      set_req(2, 1, 1, 32'h8000_0024, '0, 4'hF, 2'd2); hold_req(2, 1, 0); drain();
      chk("rej_no_arvalid", 64'(arv_cyc - s_arv), 64'd0);
      chk("rej_no_awvalid", 64'(awv_cyc - s_awv), 64'd0);

      // Bus errors, then a clean read to show the arbiter recovered.
      rresp_v = 2'b10; fix_rdata = 32'hCAFE_F00D;
      n = cyc; push(0, 32'hCAFE_F00D, 1'b1, n + 4);
      set_req(0, 1, 0, 32'h8000_0040, '0, 4'h0, 2'd2); hold_req(0, 1, 0); drain();
      rresp_v = 2'b00; bresp_v = 2'b11;
      n = cyc; push(2, '0, 1'b1, n + 4);
      set_req(2, 0, 1, 32'h8000_0044, 32'h0BAD_0BAD, 4'h3, 2'd2); hold_req(2, 1, 0); drain();
      bresp_v = 2'b00; fix_rdata = 32'h0000_1111;
      n = cyc; push(0, 32'h0000_1111, 1'b0, n + 4);
      set_req(0, 1, 0, 32'h8000_0048, '0, 4'h0, 2'd0); hold_req(0, 1, 0); drain();

      // Reset while arvalid waits on a stalled slave.
      ar_dly = 20;
      set_req(0, 1, 0, 32'h8000_0000, '0, 4'h0, 2'd2);
      n = 0;
      while (!axi_arvalid && n < 10) begin @(posedge clk); #1; n++; end
      chk("rst_mid_arvalid_seen", 64'(axi_arvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_arvalid_async", 64'(axi_arvalid), 64'd0);
      ch_r_en = '0; ch_w_en = '0;
      repeat (3) @(posedge clk);
      #1 chk("rst_mid_no_finish", 64'(ch_finish), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      ar_dly = 0; fix_en = 1'b0;

      // Round-robin after reset: all three request continuously, ch0 first.
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) push(k % 3, (32'h8000_0100 + 32'(4 * (k % 3))) ^ XK, 1'b0, -1);
      set_req(0, 1, 0, 32'h8000_0100, '0, 4'h0, 2'd2);
      set_req(1, 1, 0, 32'h8000_0104, '0, 4'h0, 2'd2);
      set_req(2, 1, 0, 32'h8000_0108, '0, 4'h0, 2'd2);
      fork
         hold_req(0, 2, 0);
         hold_req(1, 2, 0);
         hold_req(2, 2, 0);
      join
      drain();

      // Fixed priority: ch0 keeps re-requesting and starves ch1 until it stops.
      fxq.push_back(0); fxq.push_back(0); fxq.push_back(0); fxq.push_back(1);
      fx_size = {3{2'd2}};
      fx_addr = {32'h8000_0208, 32'h8000_0204, 32'h8000_0200};
      fx_r_en = 3'b011;
      fork
         hold_req(0, 3, 1);
         hold_req(1, 1, 1);
      join
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule
